muldiv_unit: RTL
================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit for the execute stage, beside the ALU; operands come from regfile rd1/rd2.
//  Executes MULT/MULTU/DIV/DIVU over multiple cycles and holds results in architectural HI/LO registers.
//  Also takes MTHI/MTLO writes. Its busy output feeds the hazard unit, which must stall any MFHI/MFLO or new mul/div.
// PARAMETERS
//  WIDTH  32  operand width; HI and LO are each WIDTH bits; iteration count = WIDTH
// PORTS
//  clk           in   1      clock, all state updates on posedge
//  reset         in   1      synchronous, active-low: reset==0 at a posedge resets the block
//  start         in   1      launch op with src_a/src_b; honoured only in IDLE
//  op            in   2      00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//  src_a         in   WIDTH  multiplicand / dividend
//  src_b         in   WIDTH  multiplier / divisor
//  cancel        in   1      pipeline flush: abort in-flight op
//  hi_we, lo_we  in   1      MTHI / MTLO write enables
//  wd            in   WIDTH  MTHI/MTLO write data
//  busy          out  1      1 while state != IDLE
//  done          out  1      one-cycle pulse after HI/LO writeback
//  div_by_zero   out  1      valid with done; 1 if the finished DIV/DIVU had src_b==0
//  hi, lo        out  WIDTH  HI/LO register contents
// BEHAVIOUR
//  - Reset (reset==0 at posedge): state=IDLE; hi=lo=0; busy=done=div_by_zero=0; iteration regs cleared.
//  - FSM states: IDLE -> CALC -> FIX -> IDLE.
//  - Edge E0, IDLE with start=1: latch op. For signed ops, latch |src_a|, |src_b| and sign bits.
//    For unsigned ops, latch raw values. Load counter=WIDTH-1. Go to CALC.
//  - CALC: one iteration per edge, E1..E_WIDTH. Counter decrements.
//    At counter==0, go to FIX (at E_WIDTH).
//  - Multiply iteration: shift-add on 2*WIDTH-bit accumulator.
//    Divide iteration: restoring shift-subtract, 1 quotient bit per edge.
//    Remainder/trial-subtract path is WIDTH+1 bits.
//  - FIX, edge E_WIDTH+1: apply sign correction, write hi/lo, go to IDLE.
//    Signed multiply: product negated if sa^sb.
//    Signed divide: quotient negated if sa^sb; remainder negated if sa.
//  - MULT*/MULTU results: hi=product[2W-1:W], lo=product[W-1:0]. DIV*/DIVU results: lo=quotient, hi=remainder.
//  - Latency: busy=1 for exactly WIDTH+1 cycles (33 at default).
//    done=1 exactly one cycle, in the cycle following E_WIDTH+1. New hi/lo are visible in that same cycle.
//  - Back-to-back: start may be asserted in the cycle done=1 (state is IDLE).
//  - start while busy: ignored; no state change. The hazard unit guarantees this does not occur.
//  - Divide by zero (src_b==0 at E0): runs full latency, skips sign fix.
//    Result: lo={WIDTH{1'b1}}, hi=src_a as latched; div_by_zero=1 with done.
//  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (wrap, no trap).
//  - cancel=1 in CALC or FIX: next edge -> IDLE; hi/lo unchanged; no done pulse.
//    cancel in IDLE has no effect. cancel takes priority over FIX writeback.
//  - hi_we/lo_we in IDLE: hi/lo <= wd at that edge.
//    Ignored while busy, including in FIX.
//  - hi_we/lo_we together with start in IDLE: both take effect; the mul/div result later overwrites.
//  - reset==0 mid-operation: aborts to reset values on that edge; reset has priority over everything.
// STRUCTURE
//  - Shared package muldiv_pkg:
//    typedef enum logic [1:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU} md_op_t
//    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_t
//  - Sub-module: muldiv_step (combinational, parameterised WIDTH).
//    Computes one mul or div iteration from {acc, operand, op}.
//  - Top: FSM, counter, sign latch, HI/LO registers using the codebase flopper style but with sync active-low reset.
// TESTING (WIDTH=32)
//  1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy 33 cycles, then done=1 one cycle; hi=0xFFFFFFFE, lo=0x00000001.
//  2. MULT 0xFFFFFFFD(-3)*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIVU 100/7 -> lo=14, hi=2.
//  3. DIV 0xFFFFFFF9(-7)/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, div_by_zero=1 with done. Then MTLO wd=0x1234 in IDLE -> lo=0x1234 next cycle.
//  5. Preload hi=0xAA, lo=0xBB. Start MULTU 3*4; pulse start again at cycle 5 (ignored).
//     Assert cancel at cycle 10 -> busy=0 next cycle; hi=0xAA, lo=0xBB; no done.
//  6. reset=0 during CALC (cycle 12) -> next cycle busy=0, hi=lo=0, done=0.
//     Next MULT 2*2 completes normally with lo=4.

Source files
------------

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
//   Shared types for the iterative multiply/divide unit.
//   md_op_t     operation code presented with start
//               (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   md_state_t  control FSM states (IDLE -> CALC -> FIX -> IDLE)
//   MD_WIDTH    default operand width
// -----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_t;

  // The high opcode bit selects divide; the low bit selects unsigned.
  function automatic logic op_is_div(input md_op_t op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input md_op_t op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
//   Bundle between the execute stage / hazard unit and the mul/div unit.
//   master : drives start, op, src_a, src_b, cancel, hi_we, lo_we, wd;
//            observes busy, done, div_by_zero, hi, lo
//   slave  : the mul/div unit itself (opposite directions)
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int WIDTH = 32
) ();
  import muldiv_pkg::*;

  logic             start;
  md_op_t           op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             cancel;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wd;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src_a, src_b, cancel, hi_we, lo_we, wd,
    input  busy, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b, cancel, hi_we, lo_we, wd,
    output busy, done, div_by_zero, hi, lo
  );

endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
//   One combinational iteration of the multiply or divide algorithm.
//   acc      in   2*WIDTH  working accumulator
//                          multiply: {partial product hi, remaining multiplier}
//                          divide  : {partial remainder, remaining dividend/quotient}
//   operand  in   WIDTH    multiplicand (multiply) or divisor (divide)
//   is_div   in   1        select divide iteration
//   acc_nxt  out  2*WIDTH  accumulator after this iteration
// -----------------------------------------------------------------------------
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    // Shift-add: add multiplicand into the top half when the current
    // multiplier bit is set, keep the carry, then shift the whole thing right.
    sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);

    // Restoring divide: bring the next dividend bit into the remainder and
    // trial-subtract. The remainder path is one bit wider so the borrow out
    // (trial[WIDTH]) tells us whether the subtraction fits.
    shifted = acc[2*WIDTH-1:WIDTH-1];
    trial   = shifted - {1'b0, operand};

    if (is_div) begin
      if (trial[WIDTH]) begin
        acc_nxt = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end else begin
        acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_nxt = {sum, acc[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
//   One algorithm step per clock; a full operation keeps busy high for
//   WIDTH+1 cycles, then done pulses for one cycle with the new HI/LO.
//   clk    in  clock, all state updates on posedge
//   reset  in  synchronous, active-low
//   md     muldiv_if.slave: start/op/src_a/src_b launch an operation, cancel
//          aborts it, hi_we/lo_we/wd are MTHI/MTLO; busy/done/div_by_zero/hi/lo
//          report status and register contents.
// -----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  md
);

  localparam int CNT_W = $clog2(WIDTH);

  md_state_t          state;
  md_state_t          state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   operand;
  logic               is_div;
  logic               is_signed;
  logic               sa;
  logic               sb;
  logic               dz;

  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               done_r;
  logic               dz_r;

  md_op_t             op_in;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  function automatic logic [WIDTH-1:0] neg_w(input logic en,
                                              input logic signed [WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic en,
                                                 input logic signed [2*WIDTH-1:0] v);
    return en ? -v : v;
  endfunction

  // Operand magnitudes; 0x80..0 stays 0x80..0, which is its correct
  // unsigned magnitude.
  assign op_in = md.op;
  assign a_neg = op_is_signed(op_in) & md.src_a[WIDTH-1];
  assign b_neg = op_is_signed(op_in) & md.src_b[WIDTH-1];
  assign mag_a = neg_w(a_neg, md.src_a);
  assign mag_b = neg_w(b_neg, md.src_b);

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc     (acc),
    .operand (operand),
    .is_div  (is_div),
    .acc_nxt (acc_step)
  );

  // Sign fix-up. sa/sb were only latched for signed ops, so unsigned ops
  // pass through unchanged. Divide by zero keeps the raw iteration result:
  // all-ones quotient and the dividend as remainder.
  always_comb begin
    prod_fix = neg_2w(sa ^ sb, acc);
    if (is_div) begin
      if (dz) begin
        res_lo = acc[WIDTH-1:0];
        res_hi = acc[2*WIDTH-1:WIDTH];
      end else begin
        res_lo = neg_w(sa ^ sb, acc[WIDTH-1:0]);
        res_hi = neg_w(sa, acc[2*WIDTH-1:WIDTH]);
      end
    end else begin
      res_lo = prod_fix[WIDTH-1:0];
      res_hi = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // ---- control FSM: state register ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= MD_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- control FSM: next state ----
  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE: if (md.start) state_nxt = MD_CALC;
      MD_CALC: begin
        if (md.cancel)      state_nxt = MD_IDLE;
        else if (cnt == '0) state_nxt = MD_FIX;
      end
      MD_FIX:  state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
  end

  // ---- datapath, counter and HI/LO ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt       <= '0;
      acc       <= '0;
      operand   <= '0;
      is_div    <= 1'b0;
      is_signed <= 1'b0;
      sa        <= 1'b0;
      sb        <= 1'b0;
      dz        <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
    end else begin
      done_r <= 1'b0;
      dz_r   <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (md.hi_we) hi_r <= md.wd;
          if (md.lo_we) lo_r <= md.wd;
          if (md.start) begin
            is_div    <= op_is_div(op_in);
            is_signed <= op_is_signed(op_in);
            sa        <= a_neg;
            sb        <= b_neg;
            dz        <= op_is_div(op_in) && (md.src_b == '0);
            cnt       <= CNT_W'(WIDTH - 1);
            // Multiply: multiplier sits in the low half and is consumed LSB
            // first. Divide: dividend sits in the low half, consumed MSB first.
            if (op_is_div(op_in)) begin
              acc     <= {{WIDTH{1'b0}}, mag_a};
              operand <= mag_b;
            end else begin
              acc     <= {{WIDTH{1'b0}}, mag_b};
              operand <= mag_a;
            end
          end
        end
        MD_CALC: begin
          if (!md.cancel) begin
            acc <= acc_step;
            if (cnt != '0) cnt <= cnt - 1'b1;
          end
        end
        MD_FIX: begin
          if (!md.cancel) begin
            hi_r   <= res_hi;
            lo_r   <= res_lo;
            done_r <= 1'b1;
            dz_r   <= dz;
          end
        end
        default: ;
      endcase
    end
  end

  assign md.busy        = (state != MD_IDLE);
  assign md.done        = done_r;
  assign md.div_by_zero = dz_r;
  assign md.hi          = hi_r;
  assign md.lo          = lo_r;

endmodule
